// File: rtl/mod_inverse.sv
// Modular inverse by binary extended Euclid, one reduction step per clock; data-dependent latency.
// No backpressure: in_valid is only taken in IDLE, otherwise it is dropped; result is a one-cycle pulse.
module mod_inverse #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opM,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [WIDTH-1:0] res_q, res_d;

  // Halving modulo an odd m: adding m to an odd x makes the shift exact.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] d;
    d = a - b;
    if (a < b) d = d + m;
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d  = opM;
          u_d  = opA;
          v_d  = opM;
          x1_d = WIDTH'(1);
          x2_d = '0;
          // Even or tiny moduli have no usable inverse; answer 0 without iterating.
          if (!opM[0] || opM < WIDTH'(3)) begin
            res_d   = '0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (u_q == WIDTH'(1)) begin
          res_d   = x1_q;
          state_d = DONE;
        end else if (v_q == WIDTH'(1)) begin
          res_d   = x2_q;
          state_d = DONE;
        end else if (u_q == '0 || v_q == '0) begin
          res_d   = '0;
          state_d = DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q, m_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q, m_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q, m_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q, m_q);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? res_q : '0;

endmodule

// File: tb/tb_mod_inverse.sv
// Bench for mod_inverse: a 256-bit instance for directed cases, a 32-bit instance for random back-to-back jobs.
module tb_mod_inverse;
  localparam int W     = 256;
  localparam int WS    = 32;
  localparam int LIM   = 4 * W + 16;
  localparam int LIM_S = 4 * WS + 16;
  localparam logic [W-1:0] SM = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_valid;
  logic [W-1:0]  opA, opM, out_data;
  logic          in_valid_s, out_valid_s;
  logic [WS-1:0] opA_s, opM_s, out_data_s;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pulses_s = 0;
  logic [W-1:0]  exp_q[$];
  logic [WS-1:0] exp_s[$];

  mod_inverse #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opA(opA), .opM(opM),
    .out_valid(out_valid), .out_data(out_data)
  );

  mod_inverse #(.WIDTH(WS)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .opA(opA_s), .opM(opM_s),
    .out_valid(out_valid_s), .out_data(out_data_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid)   pulses++;
    if (out_valid_s) pulses_s++;
  end

  function automatic longint unsigned inv_ref(input longint unsigned a, input longint unsigned m);
    longint r0, r1, t0, t1, q, tmp;
    r0 = longint'(m);
    r1 = longint'(a % m);
    t0 = 0;
    t1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;  r0 = r1;  r1 = tmp;
      tmp = t0 - q * t1;  t0 = t1;  t1 = tmp;
    end
    if (r0 != 1) return 0;
    if (t0 < 0) t0 = t0 + longint'(m);
    return t0;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] m);
    in_valid = 1'b1; opA = a; opM = m;
    @(negedge clk);
    in_valid = 1'b0; opA = '0; opM = '0;
  endtask

  task automatic wait_out(input int limit, output bit seen, output int lat, output logic [W-1:0] data);
    lat  = 1;
    seen = out_valid;
    while (!seen && lat < limit) begin
      @(negedge clk);
      lat++;
      seen = out_valid;
    end
    data = out_data;
  endtask

  task automatic test_reset();
    bit seen; int lat; logic [W-1:0] d, e;
    rst_n = 1'b0; in_valid = 1'b0; opA = '0; opM = '0;
    in_valid_s = 1'b0; opA_s = '0; opM_s = '0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_dat: got %h expected 0", out_data); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL reset_vld_s: got %b expected 0", out_valid_s); end
    checks++; if (out_data_s !== '0) begin errors++; $display("FAIL reset_dat_s: got %h expected 0", out_data_s); end
    rst_n = 1'b1;
    exp_q.push_back(W'(5));
    drive(W'(3), W'(7));
    wait_out(LIM, seen, lat, d);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin errors++; $display("FAIL first_job: timeout after %0d cycles", lat); end
    else begin
      checks++; if (d !== e) begin errors++; $display("FAIL first_job: got %h expected %h", d, e); end
      checks++; if (lat < 2) begin errors++; $display("FAIL first_lat: got %0d expected >=2", lat); end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[11], tm[11], te[11];
    int tmax[11];
    bit seen; int lat, p0; logic [W-1:0] d, e;
    ta[0] = 3;      tm[0] = 7;  te[0] = 5;      tmax[0] = LIM;
    ta[1] = 2;      tm[1] = (256'd1 << 255) - 256'd19;  te[1] = (256'd1 << 254) - 256'd9;  tmax[1] = 516;
    ta[2] = 1;      tm[2] = SM; te[2] = 1;      tmax[2] = LIM;
    ta[3] = SM - 1; tm[3] = SM; te[3] = SM - 1; tmax[3] = LIM;
    ta[4] = 6;      tm[4] = 9;  te[4] = 0;      tmax[4] = LIM;
    ta[5] = 5;      tm[5] = 8;  te[5] = 0;      tmax[5] = LIM;
    ta[6] = 0;      tm[6] = 7;  te[6] = 0;      tmax[6] = LIM;
    ta[7] = 10;     tm[7] = 7;  te[7] = 5;      tmax[7] = LIM;
    ta[8] = 7;      tm[8] = 7;  te[8] = 0;      tmax[8] = LIM;
    ta[9] = 1;      tm[9] = 1;  te[9] = 0;      tmax[9] = LIM;
    ta[10] = 2;     tm[10] = 3; te[10] = 2;     tmax[10] = LIM;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      p0 = pulses;
      exp_q.push_back(te[i]);
      drive(ta[i], tm[i]);
      wait_out(LIM, seen, lat, d);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin errors++; $display("FAIL dir%0d: timeout after %0d cycles", i, lat); end
      else begin
        checks++; if (d !== e) begin errors++; $display("FAIL dir%0d: got %h expected %h", i, d, e); end
        if (tm[i][0] && tm[i] >= W'(3)) begin
          checks++;
          if (lat < 2 || lat > tmax[i]) begin errors++; $display("FAIL dir%0d_lat: got %0d expected 2..%0d", i, lat, tmax[i]); end
        end
      end
      repeat (2) @(negedge clk);
      checks++; if (pulses != p0 + 1) begin errors++; $display("FAIL dir%0d_pulses: got %0d expected %0d", i, pulses - p0, 1); end
    end
  endtask

  task automatic test_ignore();
    bit seen; int lat, p0; logic [W-1:0] d, e;
    @(negedge clk);
    p0 = pulses;
    exp_q.push_back(SM - 1);
    drive(SM - 1, SM);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; opA = W'(3); opM = W'(7);
    @(negedge clk);
    in_valid = 1'b0; opA = '0; opM = '0;
    wait_out(LIM, seen, lat, d);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin errors++; $display("FAIL ignore_calc: timeout after %0d cycles", lat); end
    else begin
      checks++; if (d !== e) begin errors++; $display("FAIL ignore_calc: got %h expected %h", d, e); end
    end
    // in_valid held through the DONE cycle must not start a job either
    in_valid = 1'b1; opA = W'(3); opM = W'(7);
    @(negedge clk);
    in_valid = 1'b0; opA = '0; opM = '0;
    repeat (12) @(negedge clk);
    checks++; if (pulses != p0 + 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected %0d", pulses - p0, 1); end
  endtask

  task automatic test_abort();
    bit seen; int lat, p0; logic [W-1:0] d, e;
    @(negedge clk);
    p0 = pulses;
    drive(SM - 1, SM);
    repeat (20) @(negedge clk);
    in_valid = 1'b1; opA = W'(3); opM = W'(7);
    @(negedge clk);
    in_valid = 1'b0; opA = '0; opM = '0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL abort_outs: got %b/%h expected 0/0", out_valid, out_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LIM + 60) @(negedge clk);
    checks++; if (pulses != p0) begin errors++; $display("FAIL abort_pulses: got %0d expected 0", pulses - p0); end
    exp_q.push_back(W'(5));
    drive(W'(3), W'(7));
    wait_out(LIM, seen, lat, d);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin errors++; $display("FAIL after_abort: timeout after %0d cycles", lat); end
    else begin
      checks++; if (d !== e) begin errors++; $display("FAIL after_abort: got %h expected %h", d, e); end
    end
    repeat (2) @(negedge clk);
    // Reset landing in DONE must kill the pulse before the next clock edge
    p0 = pulses;
    drive(W'(3), W'(7));
    wait_out(LIM, seen, lat, d);
    checks++;
    if (!seen) begin errors++; $display("FAIL async_done: timeout after %0d cycles", lat); end
    else begin
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL async_done: got %b/%h expected 0/0", out_valid, out_data); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pulses != p0) begin errors++; $display("FAIL async_pulses: got %0d expected 0", pulses - p0); end
  endtask

  task automatic test_back_to_back();
    logic [WS-1:0] a, m, d, e;
    logic [63:0] prod;
    int lat, p0;
    p0 = pulses_s;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      m = $urandom() | 32'h8000_0001;
      a = $urandom();
      exp_s.push_back(WS'(inv_ref({32'b0, a}, {32'b0, m})));
      in_valid_s = 1'b1; opA_s = a; opM_s = m;
      @(negedge clk);
      in_valid_s = 1'b0; opA_s = '0; opM_s = '0;
      lat = 1;
      while (!out_valid_s && lat < LIM_S) begin @(negedge clk); lat++; end
      e = exp_s.pop_front();
      d = out_data_s;
      checks++;
      if (!out_valid_s) begin errors++; $display("FAIL b2b%0d: timeout after %0d cycles", i, lat); end
      else begin
        checks++;
        if (d !== e || lat < 2) begin errors++; $display("FAIL b2b%0d: a=%h m=%h got %h lat %0d expected %h lat>=2", i, a, m, d, lat, e); end
        if (e != 0) begin
          prod = ({32'b0, d} * {32'b0, a}) % {32'b0, m};
          checks++; if (prod !== 64'd1) begin errors++; $display("FAIL b2b%0d_prod: got %0d expected 1", i, prod); end
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++; if (pulses_s != p0 + 500) begin errors++; $display("FAIL b2b_pulses: got %0d expected 500", pulses_s - p0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_inverse.md
MOD_INVERSE -- requirements
Module: mod_inverse

Interface
REQ-001 Parameter WIDTH, default 256, operand/result bit width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  one-cycle start pulse; opA/opM valid this cycle only.
REQ-005 opA  input  WIDTH  operand to invert; don't-care when in_valid=0.
REQ-006 opM  input  WIDTH  modulus; don't-care when in_valid=0.
REQ-007 out_valid  output  1  one-cycle result pulse.
REQ-008 out_data  output  WIDTH  result; meaningful only while out_valid=1.

Function
REQ-009 SHALL compute out_data = opA^-1 mod opM, in range [1, opM-1], when opM odd, opM>=3 and gcd(opA,opM)=1; opA>=opM allowed.
REQ-010 SHALL output out_data=0 with out_valid=1 when opA mod opM=0, opM even, opM<3, or gcd(opA,opM)!=1.
REQ-011 FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-012 IDLE: in_valid=1 -> register opA, opM; init u=opA, v=opM, x1=1, x2=0; go CALC. Illegal opM (even or <3) -> go DONE with result 0.
REQ-013 CALC: exactly one reduction step per cycle, binary extended Euclid:
  - u even: u=u/2; x1 = x1 even ? x1/2 : (x1+opM)/2 (WIDTH+1-bit sum, no overflow loss).
  - else v even: same on v, x2.
  - else u>=v: u=u-v; x1=x1-x2, +opM if negative.
  - else: v=v-u; x2=x2-x1, +opM if negative.
REQ-014 CALC exit, checked before each step: u==1 -> result x1; v==1 -> result x2; u==0 or v==0 -> result 0; go DONE.
REQ-015 x1, x2 SHALL stay in [0, opM-1] after every step.
REQ-016 DONE: out_valid=1, out_data=result, for exactly one cycle; then IDLE.
REQ-017 out_valid=0 and out_data=0 in IDLE and CALC.
REQ-018 Latency from in_valid sample edge to out_valid high: >=2 cycles, <=2*WIDTH+4 cycles.
REQ-019 in_valid while in CALC or DONE SHALL be ignored; operands and computation unaffected.
REQ-020 in_valid sampled in IDLE on the cycle after DONE SHALL be accepted (back-to-back jobs).
REQ-021 Single job in flight; no input buffering.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, out_valid=0, out_data=0, all working registers 0, regardless of clock.
REQ-023 Reset mid-CALC SHALL abort the job; no out_valid for it after release.
REQ-024 First in_valid accepted on first rising edge with rst_n high.

Verification
REQ-025 opA=3, opM=7 -> one out_valid pulse, out_data=5.
REQ-026 opA=2, opM=2^255-19 -> out_data=0x3FFF...FFF7 (2^254-9), latency <=516 cycles.
REQ-027 opA=1 and opA=opM-1 (opM=0xFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F) -> out_data=1 and opM-1 respectively.
REQ-028 opA=6, opM=9 -> out_data=0; opA=5, opM=8 -> out_data=0; opA=0, opM=7 -> out_data=0; each with exactly one out_valid pulse.
REQ-029 Start job, pulse in_valid with other operands during CALC, then assert rst_n low mid-CALC -> out_valid stays 0; after release, opA=3, opM=7 -> 5.
REQ-030 500 random back-to-back jobs (odd WIDTH-bit opM, random opA), next in_valid one cycle after out_valid -> every out_data matches golden model, (out_data*opA) mod opM = 1 when invertible.
